// File: rtl/fdiv_seq.sv
// fdiv_seq: multi-cycle IEEE-754 single-precision divider, y = x1 / x2.
// The mantissa quotient comes from a restoring digit recurrence that produces
// RADIX_BITS quotient bits per cycle. The result is rounded to nearest, ties
// to even. The latency is the same for every operand pair, special operands
// included.
// Optional feature macro: FDIV_DZ_FLAG_EN. When it is defined, a separate dz
// output reports division by zero. When it is not defined, division by zero
// is reported on ovf.
module fdiv_seq #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
`ifdef FDIV_DZ_FLAG_EN
  ,
  output logic        dz
`endif
);

  localparam int QBITS = 26;
  localparam int NITER = (QBITS + RADIX_BITS - 1) / RADIX_BITS;
  localparam int CNT_W = $clog2(NITER);

  if (RADIX_BITS != 1 && RADIX_BITS != 2) begin : g_bad_radix
    $error("fdiv_seq: RADIX_BITS must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  cnt_reg;
  logic              sign_reg;
  logic signed [9:0] exp_reg;
  logic [23:0]       mb_reg;
  logic [24:0]       rem_reg;
  logic [QBITS-1:0]  q_reg;
  logic              spec_reg;
  logic [31:0]       spec_y_reg;
  logic              spec_ovf_reg;
`ifdef FDIV_DZ_FLAG_EN
  logic              spec_dz_reg;
`endif

  logic accept;
  assign accept    = in_valid && (state_reg == IDLE);
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

  // Operand fields. Denormal inputs (exponent 0) are treated as zero.
  logic [7:0]  e1, e2;
  logic [22:0] m1, m2;
  logic        s_in;
  logic        zero1, zero2, inf1, inf2, nan1, nan2;
  assign e1    = x1[30:23];
  assign e2    = x2[30:23];
  assign m1    = x1[22:0];
  assign m2    = x2[22:0];
  assign s_in  = x1[31] ^ x2[31];
  assign zero1 = (e1 == 8'h00);
  assign zero2 = (e2 == 8'h00);
  assign inf1  = (e1 == 8'hFF) && (m1 == 23'd0);
  assign inf2  = (e2 == 8'hFF) && (m2 == 23'd0);
  assign nan1  = (e1 == 8'hFF) && (m1 != 23'd0);
  assign nan2  = (e2 == 8'hFF) && (m2 != 23'd0);

  // Classify the special operands in priority order.
  logic        spec_hit;
  logic [31:0] spec_y;
  logic        spec_ovf;
`ifdef FDIV_DZ_FLAG_EN
  logic        spec_dz;
`endif
  // Result for a special operand pair, taken from the raw inputs.
  always_comb begin
    spec_hit = 1'b1;
    spec_y   = 32'h0;
    spec_ovf = 1'b0;
`ifdef FDIV_DZ_FLAG_EN
    spec_dz  = 1'b0;
`endif
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
      spec_y = 32'h7FC0_0000;
    end else if (inf1) begin
      spec_y = {s_in, 8'hFF, 23'h0};
    end else if (inf2) begin
      spec_y = {s_in, 31'h0};
    end else if (zero1) begin
      spec_y = {s_in, 31'h0};
    end else if (zero2) begin
      spec_y = {s_in, 8'hFF, 23'h0};
`ifdef FDIV_DZ_FLAG_EN
      spec_dz  = 1'b1;
`else
      spec_ovf = 1'b1;
`endif
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Unrolled restoring stages: RADIX_BITS quotient bits per DIV cycle.
  logic [24:0]           stage_rem [0:RADIX_BITS];
  logic [RADIX_BITS-1:0] stage_bit;
  assign stage_rem[0] = rem_reg;

  genvar gi;
  for (gi = 0; gi < RADIX_BITS; gi++) begin : g_stage
    logic        ge;
    logic [24:0] diff;
    logic [24:0] kept;
    assign ge   = stage_rem[gi] >= {1'b0, mb_reg};
    assign diff = stage_rem[gi] - {1'b0, mb_reg};
    assign kept = ge ? diff : stage_rem[gi];
    // The kept remainder is below mb (< 2^24), so the shift cannot lose a bit.
    assign stage_rem[gi+1] = kept << 1;
    assign stage_bit[RADIX_BITS-1-gi] = ge;
  end

  // Normalise, round to nearest even, then check the exponent range.
  logic              q_int;
  logic [23:0]       mant_pre;
  logic              rnd, sticky, inc;
  logic [24:0]       mant_sum;
  logic [23:0]       mant_fin;
  logic signed [9:0] e_pre, e_fin;
  logic [31:0]       rnd_y;
  logic              rnd_ovf;
  // Rounding datapath, used in the ROUND cycle.
  always_comb begin
    q_int    = q_reg[QBITS-1];
    mant_pre = q_int ? q_reg[25:2] : q_reg[24:1];
    rnd      = q_int ? q_reg[1] : q_reg[0];
    sticky   = (q_int & q_reg[0]) | (rem_reg != 25'd0);
    e_pre    = q_int ? exp_reg : exp_reg - 10'sd1;
    inc      = rnd & (sticky | mant_pre[0]);
    mant_sum = {1'b0, mant_pre} + {24'd0, inc};
    mant_fin = mant_sum[24] ? 24'h80_0000 : mant_sum[23:0];
    e_fin    = mant_sum[24] ? e_pre + 10'sd1 : e_pre;
    rnd_ovf  = 1'b0;
    if (e_fin >= 10'sd255) begin
      rnd_y   = {sign_reg, 8'hFF, 23'h0};
      rnd_ovf = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      rnd_y = {sign_reg, 31'h0};
    end else begin
      rnd_y = {sign_reg, e_fin[7:0], mant_fin[22:0]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = DIV;
      DIV:     if (cnt_reg == '0) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in DIV, write the result in ROUND.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_reg      <= '0;
      sign_reg     <= 1'b0;
      exp_reg      <= '0;
      mb_reg       <= '0;
      rem_reg      <= '0;
      q_reg        <= '0;
      spec_reg     <= 1'b0;
      spec_y_reg   <= '0;
      spec_ovf_reg <= 1'b0;
      y            <= '0;
      ovf          <= 1'b0;
`ifdef FDIV_DZ_FLAG_EN
      spec_dz_reg  <= 1'b0;
      dz           <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt_reg      <= CNT_W'(NITER - 1);
        sign_reg     <= s_in;
        exp_reg      <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
        mb_reg       <= {1'b1, m2};
        rem_reg      <= {2'b01, m1};
        q_reg        <= '0;
        spec_reg     <= spec_hit;
        spec_y_reg   <= spec_y;
        spec_ovf_reg <= spec_ovf;
`ifdef FDIV_DZ_FLAG_EN
        spec_dz_reg  <= spec_dz;
`endif
      end
      if (state_reg == DIV) begin
        cnt_reg <= cnt_reg - 1'b1;
        rem_reg <= stage_rem[RADIX_BITS];
        q_reg   <= {q_reg[QBITS-1-RADIX_BITS:0], stage_bit};
      end
      if (state_reg == ROUND) begin
        y   <= spec_reg ? spec_y_reg : rnd_y;
        ovf <= spec_reg ? spec_ovf_reg : rnd_ovf;
`ifdef FDIV_DZ_FLAG_EN
        dz  <= spec_reg & spec_dz_reg;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed testbench for fdiv_seq. It covers the arithmetic, the special
// operands, the fixed latency, backpressure and reset in the middle of an
// operation. It runs with or without FDIV_DZ_FLAG_EN.
module tb_fdiv_seq;

  parameter int RADIX_BITS = 1;
  localparam int NITER = (26 + RADIX_BITS - 1) / RADIX_BITS;
`ifdef FDIV_DZ_FLAG_EN
  localparam logic DZ_OVF = 1'b0;
`else
  localparam logic DZ_OVF = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1, x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
`ifdef FDIV_DZ_FLAG_EN
  logic        dz;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] got_y;
  logic        got_ovf;
`ifdef FDIV_DZ_FLAG_EN
  logic        got_dz;
`endif
  int          got_lat;

  fdiv_seq #(.RADIX_BITS(RADIX_BITS)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
`ifdef FDIV_DZ_FLAG_EN
    ,
    .dz        (dz)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid, counting rising edges. A return of -1 means the wait timed out.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Send one operand pair, capture the result and latency, then hand the result off.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; x1 = a; x2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; x1 = 32'hDEAD_BEEF; x2 = 32'h1234_5678;
    wait_valid(got_lat);
    got_y   = y;
    got_ovf = ovf;
`ifdef FDIV_DZ_FLAG_EN
    got_dz  = dz;
`endif
    $display("op %08h / %08h -> y=%08h ovf=%0b latency=%0d", a, b, got_y, got_ovf, got_lat);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_y, input logic exp_ovf, input logic exp_dz);
    run_op(a, b);
    chk({tag, "_y"}, got_y, exp_y);
    chk({tag, "_ovf"}, {31'd0, got_ovf}, {31'd0, exp_ovf});
    chk({tag, "_lat"}, 32'(got_lat), 32'(NITER + 1));
`ifdef FDIV_DZ_FLAG_EN
    chk({tag, "_dz"}, {31'd0, got_dz}, {31'd0, exp_dz});
`else
    if (exp_dz) chk({tag, "_dz_as_ovf"}, {31'd0, got_ovf}, 32'd1);
`endif
  endtask

  initial begin
    int  lat;
    logic seen;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", y, 32'h0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`ifdef FDIV_DZ_FLAG_EN
    chk("rst_dz", {31'd0, dz}, 32'd0);
`endif
    @(negedge clk); rstn = 1'b1;

    // Arithmetic.
    op_check("six_by_two",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
    op_check("one_third",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0);
    op_check("two_third",   32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 1'b0, 1'b0);
    op_check("one_by_one",  32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
    op_check("neg_5_by_2",  32'hC0A0_0000, 32'h4000_0000, 32'hC020_0000, 1'b0, 1'b0);
    // Exponent boundaries.
    op_check("overflow",    32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b1, 1'b0);
    op_check("underflow",   32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 1'b0, 1'b0);
    // Special operands.
    op_check("div_zero",    32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, DZ_OVF, 1'b1);
    op_check("zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0);
    op_check("inf_by_two",  32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b0);
    op_check("one_by_ninf", 32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0);
    op_check("nan_in",      32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
    op_check("inf_inf",     32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);

    // Backpressure: hold the result and ignore a new in_valid pulse.
    @(negedge clk);
    in_valid = 1'b1; x1 = 32'h40C0_0000; x2 = 32'h4000_0000;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'(NITER + 1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k == 2); x1 = 32'h3F80_0000; x2 = 32'h4040_0000;
      @(posedge clk); #1; in_valid = 1'b0;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_y", y, 32'h4040_0000);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    $display("backpressure hold: y=%08h out_valid=%0b", y, out_valid);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (NITER + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("bp_pulse_ignored", {31'd0, seen}, 32'd0);

    // Reset in the middle of DIV discards the operation.
    @(negedge clk);
    in_valid = 1'b1; x1 = 32'h3F80_0000; x2 = 32'h4040_0000;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    seen = 1'b0;
    repeat (NITER + 5) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    $display("reset mid-DIV: out_valid seen=%0b", seen);
    chk("midrst_no_output", {31'd0, seen}, 32'd0);
    op_check("after_reset", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
